booth_r4_mult: RTL

Parametrised radix-4 Booth multiplier, the successor to the radix-2 24-bit Booth unit. It multiplies two W-bit operands in either signed (two's complement) or unsigned mode, retiring two multiplier bits per cycle. It uses an internal adder, so no external adder handshake is needed. It sits in the FPU mantissa datapath behind the same BREQ/BACK request–acknowledge protocol. The result is held stable between operations.

---
 rtl/booth_r4_mult_if.sv | 25 ++
 rtl/booth_r4_mult.sv | 125 ++++++++++++
 2 files changed

// File: rtl/booth_r4_mult_if.sv
// Request/acknowledge bundle for the radix-4 Booth multiplier.
// The requester drives the operands and BREQ; the multiplier returns the product and status.
interface booth_r4_mult_if #(
  parameter int unsigned W = 24
) ();

  logic           BREQ;
  logic           BSIGNED;
  logic [W-1:0]   m1;
  logic [W-1:0]   m2;
  logic [2*W-1:0] res;
  logic           BACK;
  logic           BBUSY;

  modport master (
    output BREQ, BSIGNED, m1, m2,
    input  res, BACK, BBUSY
  );

  modport slave (
    input  BREQ, BSIGNED, m1, m2,
    output res, BACK, BBUSY
  );

endinterface

// File: rtl/booth_r4_mult.sv
// Radix-4 Booth multiplier, signed or unsigned W-bit operands, two multiplier bits per cycle.
// Operands are widened to an even width E so that unsigned values stay positive under the
// signed Booth recoding; the product is the low 2W bits of {A,Q} after E/2 iterations.
module booth_r4_mult #(
  parameter int unsigned W = 24
) (
  input logic            CLK,
  input logic            RSTK,
  booth_r4_mult_if.slave bus
);

  localparam int unsigned E  = (W % 2 == 0) ? W + 2 : W + 3;
  localparam int unsigned N  = E / 2;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e         state_q, state_d;
  logic [E+1:0]   m_q, m_d;
  logic [E+1:0]   a_q, a_d;
  logic [E-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] res_q, res_d;

  logic           sgn1, sgn2;
  logic [E+1:0]   m_ld;
  logic [E-1:0]   q_ld;
  logic [E+1:0]   x_sel;
  logic           neg;
  logic [E+1:0]   sum;
  logic [E+1:0]   a_sh;
  logic [E-1:0]   q_sh;
  logic [2*W-1:0] res_nxt;

  // Operand extension, Booth digit decode, add/subtract and the 2-bit arithmetic shift.
  always_comb begin
    sgn1  = bus.BSIGNED & bus.m1[W-1];
    sgn2  = bus.BSIGNED & bus.m2[W-1];
    m_ld  = {{(E + 2 - W){sgn1}}, bus.m1};
    q_ld  = {{(E - W){sgn2}}, bus.m2};
    x_sel = '0;
    neg   = 1'b0;
    unique case ({q_q[1:0], q1_q})
      3'b001, 3'b010: x_sel = m_q;
      3'b011:         x_sel = {m_q[E:0], 1'b0};
      3'b100: begin
        x_sel = {m_q[E:0], 1'b0};
        neg   = 1'b1;
      end
      3'b101, 3'b110: begin
        x_sel = m_q;
        neg   = 1'b1;
      end
      default:        x_sel = '0;
    endcase
    // Subtraction as A + ~X + 1; the carry out of E+2 bits is dropped.
    sum     = a_q + (neg ? ~x_sel : x_sel) + {{(E + 1){1'b0}}, neg};
    a_sh    = {{2{sum[E+1]}}, sum[E+1:2]};
    q_sh    = {sum[1:0], q_q[E-1:2]};
    res_nxt = (2 * W)'({a_sh, q_sh});
  end

  // Next-state and register updates for the IDLE/COMPUTE/DONE sequence.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (bus.BREQ) begin
          m_d     = m_ld;
          a_d     = '0;
          q_d     = q_ld;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          res_d   = res_nxt;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any operation and clears the held result.
  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      state_q <= StIdle;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.res   = res_q;
  assign bus.BACK  = (state_q == StDone);
  assign bus.BBUSY = (state_q != StIdle);

endmodule
